// File: rtl/exc_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_commit_ctrl
// Summary  : Exception / ERTN commit sequencer: optional bus drain, ordered
//            CSR updates (one write per cycle), then a single fetch redirect.
//            Optional drain stage and outstanding counters: EXC_DRAIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exc_commit_ctrl #(
    parameter int OUTS_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_ertn,
    input  logic [5:0]  ex_ecode,
    input  logic [7:0]  ex_esubcode,
    input  logic [31:0] ex_pc,
    input  logic        ex_badv_valid,
    input  logic [31:0] ex_badv,
    input  logic        inst_req_acc,
    input  logic        inst_resp_done,
    input  logic        data_req_acc,
    input  logic        data_resp_done,
    input  logic [31:0] csr_crmd,
    input  logic [31:0] csr_prmd,
    input  logic [31:0] csr_era,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [5:0]  csr_estat_ecode,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    output logic        flush,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_UPDATE   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam logic [5:0]  c_ECODE_TLBR = 6'h3f;
    localparam logic [13:0] c_CSR_CRMD   = 14'h0000;
    localparam logic [13:0] c_CSR_PRMD   = 14'h0001;
    localparam logic [13:0] c_CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] c_CSR_ERA    = 14'h0006;
    localparam logic [13:0] c_CSR_BADV   = 14'h0007;

    state_t      r_state;
    logic [2:0]  r_step;
    logic        r_is_ertn;
    logic [5:0]  r_ecode;
    logic [7:0]  r_esubcode;
    logic [31:0] r_pc;
    logic        r_badv_valid;
    logic [31:0] r_badv;

    logic        w_drain_done;
    logic        w_last_step;
    logic        w_is_tlbr;

`ifdef EXC_DRAIN_EN
    localparam logic [OUTS_W-1:0] c_CNT_ONE = {{(OUTS_W-1){1'b0}}, 1'b1};

    logic [OUTS_W-1:0] r_inst_cnt;
    logic [OUTS_W-1:0] r_data_cnt;
    logic [OUTS_W-1:0] w_inst_cnt_nxt;
    logic [OUTS_W-1:0] w_data_cnt_nxt;

    // Saturating at both ends; simultaneous accept and completion cancel out.
    function automatic logic [OUTS_W-1:0] cnt_next(
        input logic [OUTS_W-1:0] cnt,
        input logic              inc,
        input logic              dec
    );
        logic [OUTS_W-1:0] res;
        res = cnt;
        if (inc && !dec && (cnt != '1)) begin
            res = cnt + c_CNT_ONE;
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - c_CNT_ONE;
        end
        return res;
    endfunction

    assign w_inst_cnt_nxt = cnt_next(r_inst_cnt, inst_req_acc, inst_resp_done);
    assign w_data_cnt_nxt = cnt_next(r_data_cnt, data_req_acc, data_resp_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_cnt <= '0;
            r_data_cnt <= '0;
        end else begin
            r_inst_cnt <= w_inst_cnt_nxt;
            r_data_cnt <= w_data_cnt_nxt;
        end
    end

    // Leave DRAIN in the cycle whose completions bring both counts to zero.
    assign w_drain_done = (w_inst_cnt_nxt == '0) && (w_data_cnt_nxt == '0);
`else
    logic              w_unused_hs;
    logic [OUTS_W-1:0] w_unused_cnt;
    assign w_unused_hs  = ^{inst_req_acc, inst_resp_done, data_req_acc, data_resp_done};
    assign w_unused_cnt = '0;
    assign w_drain_done = 1'b1;
`endif

    assign w_is_tlbr   = (r_ecode == c_ECODE_TLBR);
    assign w_last_step = r_is_ertn    ? (r_step == 3'd0) :
                         r_badv_valid ? (r_step == 3'd4) :
                                        (r_step == 3'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_step       <= 3'd0;
            r_is_ertn    <= 1'b0;
            r_ecode      <= 6'd0;
            r_esubcode   <= 8'd0;
            r_pc         <= 32'd0;
            r_badv_valid <= 1'b0;
            r_badv       <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_valid) begin
                        r_is_ertn    <= ex_is_ertn;
                        r_ecode      <= ex_ecode;
                        r_esubcode   <= ex_esubcode;
                        r_pc         <= ex_pc;
                        r_badv_valid <= ex_badv_valid;
                        r_badv       <= ex_badv;
                        r_step       <= 3'd0;
`ifdef EXC_DRAIN_EN
                        r_state      <= ST_DRAIN;
`else
                        r_state      <= ST_UPDATE;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (w_last_step) begin
                        r_step  <= 3'd0;
                        r_state <= ST_REDIRECT;
                    end else begin
                        r_step  <= r_step + 3'd1;
                    end
                end
                ST_REDIRECT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ex_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign flush    = (r_state != ST_IDLE);

    // PRMD and ERTN CRMD data come straight from the live CSR inputs, so the
    // PRMD step sees CRMD before it is rewritten in the following step.
    always_comb begin
        csr_we    = 1'b0;
        csr_num   = 14'd0;
        csr_wmask = 32'd0;
        csr_wdata = 32'd0;
        if (r_state == ST_UPDATE) begin
            csr_we = 1'b1;
            if (r_is_ertn) begin
                csr_num = c_CSR_CRMD;
                if (csr_estat_ecode == c_ECODE_TLBR) begin
                    csr_wmask = 32'h0000_001f;
                    csr_wdata = {27'd0, 1'b1, 1'b0, csr_prmd[2], csr_prmd[1:0]};
                end else begin
                    csr_wmask = 32'h0000_0007;
                    csr_wdata = {29'd0, csr_prmd[2], csr_prmd[1:0]};
                end
            end else begin
                case (r_step)
                    3'd0: begin
                        csr_num   = c_CSR_ERA;
                        csr_wmask = 32'hffff_ffff;
                        csr_wdata = r_pc;
                    end
                    3'd1: begin
                        csr_num   = c_CSR_PRMD;
                        csr_wmask = 32'h0000_0007;
                        csr_wdata = {29'd0, csr_crmd[2], csr_crmd[1:0]};
                    end
                    3'd2: begin
                        csr_num = c_CSR_CRMD;
                        if (w_is_tlbr) begin
                            csr_wmask = 32'h0000_001f;
                            csr_wdata = 32'h0000_0008;
                        end else begin
                            csr_wmask = 32'h0000_0007;
                            csr_wdata = 32'h0000_0000;
                        end
                    end
                    3'd3: begin
                        csr_num   = c_CSR_ESTAT;
                        csr_wmask = 32'h7fff_0000;
                        csr_wdata = {1'b0, 1'b0, r_esubcode, r_ecode, 16'h0000};
                    end
                    3'd4: begin
                        csr_num   = c_CSR_BADV;
                        csr_wmask = 32'hffff_ffff;
                        csr_wdata = r_badv;
                    end
                    default: begin
                        csr_we = 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if (r_state == ST_REDIRECT) begin
            redirect_valid = 1'b1;
            if (r_is_ertn) begin
                redirect_pc = csr_era;
            end else if (w_is_tlbr) begin
                redirect_pc = csr_tlbrentry;
            end else begin
                redirect_pc = csr_eentry;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_commit_ctrl
// Summary  : Self-checking bench for exc_commit_ctrl: queue-based reference
//            model, directed scenarios with literal expectations, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_commit_ctrl;

`ifdef EXC_DRAIN_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif
    localparam int CNT_MAX = 15;

    localparam int K_ERA   = 0;
    localparam int K_PRMD  = 1;
    localparam int K_CRMD  = 2;
    localparam int K_ESTAT = 3;
    localparam int K_BADV  = 4;
    localparam int K_ERTN  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_is_ertn = 1'b0;
    logic [5:0]  ex_ecode = 6'd0;
    logic [7:0]  ex_esubcode = 8'd0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_badv_valid = 1'b0;
    logic [31:0] ex_badv = 32'd0;
    logic        inst_req_acc = 1'b0;
    logic        inst_resp_done = 1'b0;
    logic        data_req_acc = 1'b0;
    logic        data_resp_done = 1'b0;
    logic [31:0] csr_crmd = 32'd0;
    logic [31:0] csr_prmd = 32'd0;
    logic [31:0] csr_era = 32'd0;
    logic [31:0] csr_eentry = 32'd0;
    logic [31:0] csr_tlbrentry = 32'd0;
    logic [5:0]  csr_estat_ecode = 6'd0;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    exc_commit_ctrl dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_ertn(ex_is_ertn),
        .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode), .ex_pc(ex_pc),
        .ex_badv_valid(ex_badv_valid), .ex_badv(ex_badv),
        .inst_req_acc(inst_req_acc), .inst_resp_done(inst_resp_done),
        .data_req_acc(data_req_acc), .data_resp_done(data_resp_done),
        .csr_crmd(csr_crmd), .csr_prmd(csr_prmd), .csr_era(csr_era),
        .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry),
        .csr_estat_ecode(csr_estat_ecode),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .flush(flush), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Event = list of pending CSR writes; phase 0 idle, 1 waiting for bus,
    // 2 writing, 3 redirect.
    int          m_phase = 0;
    int          m_inst = 0;
    int          m_data = 0;
    int          m_q[$];
    logic        m_ertn = 1'b0;
    logic [5:0]  m_ecode = 6'd0;
    logic [7:0]  m_esub = 8'd0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_badv = 32'd0;
    int          m_ni;
    int          m_nd;

    function automatic int cnt_step(input int c, input logic acc, input logic done);
        if (acc && !done) return (c < CNT_MAX) ? c + 1 : c;
        if (done && !acc) return (c > 0) ? c - 1 : c;
        return c;
    endfunction

    function automatic void exp_write(input int k, output logic [13:0] n,
                                      output logic [31:0] mk, output logic [31:0] d);
        n = 14'd0; mk = 32'd0; d = 32'd0;
        case (k)
            K_ERA:   begin n = 14'd6; mk = 32'hffffffff; d = m_pc; end
            K_PRMD:  begin n = 14'd1; mk = 32'h7; d = csr_crmd & 32'h7; end
            K_CRMD:  begin
                n = 14'd0;
                if (m_ecode == 6'h3f) begin mk = 32'h1f; d = 32'h8; end
                else begin mk = 32'h7; d = 32'h0; end
            end
            K_ESTAT: begin
                n = 14'd5; mk = 32'h7fff0000;
                d = (32'(m_esub) << 22) | (32'(m_ecode) << 16);
            end
            K_BADV:  begin n = 14'd7; mk = 32'hffffffff; d = m_badv; end
            default: begin
                n = 14'd0;
                if (csr_estat_ecode == 6'h3f) begin mk = 32'h1f; d = (csr_prmd & 32'h7) | 32'h10; end
                else begin mk = 32'h7; d = csr_prmd & 32'h7; end
            end
        endcase
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_phase = 0; m_inst = 0; m_data = 0; m_q.delete();
            m_ertn = 1'b0; m_ecode = 6'd0; m_esub = 8'd0; m_pc = 32'd0; m_badv = 32'd0;
        end else begin
            m_ni = cnt_step(m_inst, inst_req_acc, inst_resp_done);
            m_nd = cnt_step(m_data, data_req_acc, data_resp_done);
            case (m_phase)
                0: if (ex_valid) begin
                    m_ertn = ex_is_ertn; m_ecode = ex_ecode; m_esub = ex_esubcode;
                    m_pc = ex_pc; m_badv = ex_badv;
                    m_q.delete();
                    if (ex_is_ertn) m_q.push_back(K_ERTN);
                    else begin
                        m_q.push_back(K_ERA); m_q.push_back(K_PRMD);
                        m_q.push_back(K_CRMD); m_q.push_back(K_ESTAT);
                        if (ex_badv_valid) m_q.push_back(K_BADV);
                    end
                    m_phase = (D != 0) ? 1 : 2;
                end
                1: if (m_ni == 0 && m_nd == 0) m_phase = 2;
                2: begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
            if (D != 0) begin
                m_inst = m_ni;
                m_data = m_nd;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [13:0] e_num;
    logic [31:0] e_mask, e_data, e_rpc;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            if (m_phase == 2) exp_write(m_q[0], e_num, e_mask, e_data);
            else begin e_num = 14'd0; e_mask = 32'd0; e_data = 32'd0; end
            e_rpc = 32'd0;
            if (m_phase == 3) e_rpc = m_ertn ? csr_era : (m_ecode == 6'h3f) ? csr_tlbrentry : csr_eentry;
            chk("m_ex_ready", 32'(ex_ready), 32'(m_phase == 0));
            chk("m_busy", 32'(busy), 32'(m_phase != 0));
            chk("m_flush", 32'(flush), 32'(m_phase != 0));
            chk("m_csr_we", 32'(csr_we), 32'(m_phase == 2));
            chk("m_csr_num", 32'(csr_num), 32'(e_num));
            chk("m_csr_wmask", csr_wmask, e_mask);
            chk("m_csr_wdata", csr_wdata, e_data);
            chk("m_redirect_valid", 32'(redirect_valid), 32'(m_phase == 3));
            chk("m_redirect_pc", redirect_pc, e_rpc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ertn, input logic [5:0] ec, input logic [7:0] es,
                        input logic [31:0] pc, input logic bv, input logic [31:0] badv);
        ex_is_ertn = ertn; ex_ecode = ec; ex_esubcode = es; ex_pc = pc;
        ex_badv_valid = bv; ex_badv = badv; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
    endtask

    int wcount;
    int rcount;

    initial begin
        csr_crmd = 32'h7; csr_prmd = 32'h5; csr_era = 32'h1C000200;
        csr_eentry = 32'h1C008000; csr_tlbrentry = 32'h1C00F000; csr_estat_ecode = 6'h0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_csr_we", 32'(csr_we), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        cmp_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Exception 0x0B, no BADV
        send(1'b0, 6'h0B, 8'h00, 32'h1C000100, 1'b0, 32'h0);
        repeat (D) tick();
        #2 chk("t1_era_num", 32'(csr_num), 32'h6);
        chk("t1_era_data", csr_wdata, 32'h1C000100);
        tick(); #2 chk("t1_prmd_num", 32'(csr_num), 32'h1);
        chk("t1_prmd_data", csr_wdata, 32'h7);
        tick(); #2 chk("t1_crmd_mask", csr_wmask, 32'h7);
        chk("t1_crmd_data", csr_wdata, 32'h0);
        tick(); #2 chk("t1_estat_num", 32'(csr_num), 32'h5);
        chk("t1_estat_data", csr_wdata, 32'h000B0000);
        tick(); #2 chk("t1_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("t1_redirect_pc", redirect_pc, 32'h1C008000);
        tick(); #2 chk("t1_ready_after", 32'(ex_ready), 32'd1);
        tick();

        // TLBR with BADV
        send(1'b0, 6'h3f, 8'h00, 32'h1C000300, 1'b1, 32'h00400000);
        repeat (D) tick();
        tick(); tick(); #2 chk("t2_crmd_mask", csr_wmask, 32'h1F);
        chk("t2_crmd_data", csr_wdata, 32'h08);
        tick(); #2 chk("t2_estat_data", csr_wdata, 32'h003F0000);
        tick(); #2 chk("t2_badv_num", 32'(csr_num), 32'h7);
        chk("t2_badv_data", csr_wdata, 32'h00400000);
        tick(); #2 chk("t2_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("t2_redirect_pc", redirect_pc, 32'h1C00F000);
        tick(); tick();

        // ERTN returning from TLBR refill
        csr_estat_ecode = 6'h3f;
        send(1'b1, 6'h00, 8'h00, 32'h0, 1'b0, 32'h0);
        repeat (D) tick();
        #2 chk("t3_crmd_mask", csr_wmask, 32'h1F);
        chk("t3_crmd_data", csr_wdata, 32'h15);
        tick(); #2 chk("t3_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("t3_redirect_pc", redirect_pc, 32'h1C000200);
        tick(); tick();
        csr_estat_ecode = 6'h0;

`ifdef EXC_DRAIN_EN
        // Two outstanding fetches, responses at T+3 and T+5
        inst_req_acc = 1'b1; tick(); tick(); inst_req_acc = 1'b0;
        send(1'b0, 6'h0B, 8'h00, 32'h1C000400, 1'b0, 32'h0);
        tick(); tick();
        inst_resp_done = 1'b1;
        #2 chk("t4_flush_t3", 32'(flush), 32'd1);
        chk("t4_we_t3", 32'(csr_we), 32'd0);
        tick(); inst_req_acc = 1'b1; inst_resp_done = 1'b1;
        #2 chk("t4_flush_t4", 32'(flush), 32'd1);
        tick(); inst_req_acc = 1'b0; inst_resp_done = 1'b1;
        #2 chk("t4_we_t5", 32'(csr_we), 32'd0);
        chk("t4_flush_t5", 32'(flush), 32'd1);
        tick(); inst_resp_done = 1'b0;
        #2 chk("t4_we_t6", 32'(csr_we), 32'd1);
        chk("t4_num_t6", 32'(csr_num), 32'h6);
        repeat (6) tick();
`endif

        // Second event while busy must be ignored
        send(1'b0, 6'h0B, 8'h00, 32'h1C000500, 1'b0, 32'h0);
        wcount = 0; rcount = 0;
        for (int c = 1; c <= 10; c++) begin
            ex_valid = (c < 5 + D);
            ex_ecode = 6'h01; ex_badv_valid = 1'b1;
            #2;
            if (csr_we) wcount++;
            if (redirect_valid) rcount++;
            tick();
        end
        ex_valid = 1'b0;
        chk("t5_write_count", 32'(wcount), 32'd4);
        chk("t5_redirect_count", 32'(rcount), 32'd1);
        tick();

        // Reset during the PRMD step
        send(1'b0, 6'h0B, 8'h00, 32'h1C000600, 1'b1, 32'h1234);
        repeat (D) tick();
        tick();
        #1 chk("t6_pre_num", 32'(csr_num), 32'h1);
        reset = 1'b1;
        #1 chk("t6_we", 32'(csr_we), 32'd0);
        chk("t6_flush", 32'(flush), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(ex_ready), 32'd1);
        chk("t6_wdata", csr_wdata, 32'd0);
        tick(); reset = 1'b0;
        wcount = 0; rcount = 0;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (csr_we) wcount++;
            if (redirect_valid) rcount++;
            tick();
        end
        chk("t6_no_writes", 32'(wcount), 32'd0);
        chk("t6_no_redirect", 32'(rcount), 32'd0);

        // Random traffic; alternating segments fill and empty the counters
        for (int i = 0; i < 4000; i++) begin
            automatic bit fill = ((i / 500) % 2) == 0;
            ex_valid       = ($urandom_range(0, 3) == 0);
            ex_is_ertn     = ($urandom_range(0, 3) == 0);
            ex_ecode       = ($urandom_range(0, 3) == 0) ? 6'h3f : 6'($urandom_range(0, 63));
            ex_esubcode    = 8'($urandom);
            ex_pc          = $urandom;
            ex_badv_valid  = 1'($urandom_range(0, 1));
            ex_badv        = $urandom;
            inst_req_acc   = fill ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            data_req_acc   = fill ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            inst_resp_done = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            data_resp_done = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            csr_crmd       = $urandom;
            csr_prmd       = $urandom;
            csr_era        = $urandom;
            csr_eentry     = $urandom;
            csr_tlbrentry  = $urandom;
            csr_estat_ecode = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'($urandom_range(0, 63));
            reset          = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0; ex_valid = 1'b0;
        inst_req_acc = 1'b0; data_req_acc = 1'b0; inst_resp_done = 1'b0; data_resp_done = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
